// File: rtl/dma_block_mover_if.sv
// rtl/dma_block_mover_if.sv - sequencer channel access bus between a requester and the dma_access path
interface dma_block_mover_if #(
    parameter int AW = 21
);
    logic          dma_req;
    logic          dma_rnw;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wd;
    logic          dma_ack;
    logic          dma_end;
    logic [7:0]    dma_rd;

    modport master (
        output dma_req, dma_rnw, dma_addr, dma_wd,
        input  dma_ack, dma_end, dma_rd
    );

    modport slave (
        input  dma_req, dma_rnw, dma_addr, dma_wd,
        output dma_ack, dma_end, dma_rd
    );
endinterface

// File: rtl/dma_block_mover.sv
// rtl/dma_block_mover.sv - byte-wise copy/fill block transfer engine on one sequencer channel
module dma_block_mover #(
    parameter int AW = 21,
    parameter int LW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [AW-1:0]     i_cfg_src,
    input  logic [AW-1:0]     i_cfg_dst,
    input  logic [LW-1:0]     i_cfg_len,
    input  logic              i_cfg_fill,
    input  logic [7:0]        i_cfg_pat,
    input  logic              i_cfg_sinc,
    input  logic              i_cfg_dinc,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [LW-1:0]     o_remaining,
    dma_block_mover_if.master bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    logic [2:0]    r_state;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [LW-1:0] r_rem;
    logic          r_fill;
    logic [7:0]    r_pat;
    logic          r_sinc;
    logic          r_dinc;
    logic [7:0]    r_data;
    logic          r_abort_pend;
    logic          r_aborted;

    logic          w_wr_done;
    logic          w_stop;

    // A write is finished either by a separate end in WR_WAIT or by ack+end together.
    assign w_wr_done = ((r_state == S_WR_REQ) && bus.dma_ack && bus.dma_end) ||
                       ((r_state == S_WR_WAIT) && bus.dma_end);
    assign w_stop    = r_abort_pend | i_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_rem        <= '0;
            r_fill       <= 1'b0;
            r_pat        <= '0;
            r_sinc       <= 1'b0;
            r_dinc       <= 1'b0;
            r_data       <= '0;
            r_abort_pend <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_src        <= i_cfg_src;
                        r_dst        <= i_cfg_dst;
                        r_rem        <= i_cfg_len;
                        r_fill       <= i_cfg_fill;
                        r_pat        <= i_cfg_pat;
                        r_sinc       <= i_cfg_sinc;
                        r_dinc       <= i_cfg_dinc;
                        r_aborted    <= 1'b0;
                        r_abort_pend <= 1'b0;
                        if (i_cfg_len == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= i_cfg_fill ? S_WR_REQ : S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (bus.dma_ack) begin
                        if (bus.dma_end) begin
                            r_data <= bus.dma_rd;
                            // Read already complete: an abort here must not write it.
                            if (i_abort) begin
                                r_aborted <= 1'b1;
                                r_state   <= S_FIN;
                            end else begin
                                r_state <= S_WR_REQ;
                            end
                        end else begin
                            r_abort_pend <= i_abort;
                            r_state      <= S_RD_WAIT;
                        end
                    end else if (i_abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_FIN;
                    end
                end
                S_RD_WAIT: begin
                    if (i_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (bus.dma_end) begin
                        r_data <= bus.dma_rd;
                        if (w_stop) begin
                            r_aborted <= 1'b1;
                            r_state   <= S_FIN;
                        end else begin
                            r_state <= S_WR_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (bus.dma_ack) begin
                        if (!bus.dma_end) begin
                            r_abort_pend <= i_abort;
                            r_state      <= S_WR_WAIT;
                        end
                    end else if (i_abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_FIN;
                    end
                end
                S_WR_WAIT: begin
                    if (i_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_abort_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_wr_done) begin
                r_rem <= r_rem - LW'(1);
                r_src <= r_src + AW'(r_sinc);
                r_dst <= r_dst + AW'(r_dinc);
                if (w_stop) begin
                    r_aborted <= 1'b1;
                    r_state   <= S_FIN;
                end else if (r_rem == LW'(1)) begin
                    r_state <= S_FIN;
                end else begin
                    r_state <= r_fill ? S_WR_REQ : S_RD_REQ;
                end
            end
        end
    end

    assign bus.dma_req  = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
    assign bus.dma_rnw  = (r_state != S_WR_REQ);
    assign bus.dma_addr = (r_state == S_WR_REQ) ? r_dst : r_src;
    assign bus.dma_wd   = r_fill ? r_pat : r_data;

    assign o_busy      = (r_state != S_IDLE) && (r_state != S_FIN);
    assign o_done      = (r_state == S_FIN);
    assign o_aborted   = r_aborted;
    assign o_remaining = r_rem;

endmodule

// File: tb/tb_dma_block_mover.sv
// tb/tb_dma_block_mover.sv - randomized bench for dma_block_mover against a sequential transfer model
module tb_dma_block_mover;

    localparam int AW = 21;
    localparam int LW = 16;

    typedef struct packed {
        logic          rnw;
        logic [AW-1:0] addr;
        logic [7:0]    wd;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] cfg_src;
    logic [AW-1:0] cfg_dst;
    logic [LW-1:0] cfg_len;
    logic          cfg_fill;
    logic [7:0]    cfg_pat;
    logic          cfg_sinc;
    logic          cfg_dinc;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] remaining;

    dma_block_mover_if #(.AW(AW)) bus();

    dma_block_mover #(.AW(AW), .LW(LW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_abort     (abort),
        .i_cfg_src   (cfg_src),
        .i_cfg_dst   (cfg_dst),
        .i_cfg_len   (cfg_len),
        .i_cfg_fill  (cfg_fill),
        .i_cfg_pat   (cfg_pat),
        .i_cfg_sinc  (cfg_sinc),
        .i_cfg_dinc  (cfg_dinc),
        .o_busy      (busy),
        .o_done      (done),
        .o_aborted   (aborted),
        .o_remaining (remaining),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem     [logic [AW-1:0]];
    logic [7:0] ref_mem [logic [AW-1:0]];
    acc_t log_q[$];
    acc_t exp_q[$];

    int   lat_lo = 1, lat_hi = 1, gap_hi = 0;
    bit   stall_rd = 0, stall_wr = 0;
    int   pend_cnt = 0, gap = 0, lat = 0;
    int   done_cnt = 0, req_cnt = 0;
    acc_t cur;

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Sequencer/memory responder: random ack delay, random access latency (0 = end with ack).
    initial begin
        bus.dma_ack = 1'b0;
        bus.dma_end = 1'b0;
        bus.dma_rd  = 8'h00;
        forever begin
            @(negedge clk);
            bus.dma_ack = 1'b0;
            bus.dma_end = 1'b0;
            if (done === 1'b1) done_cnt++;
            if (bus.dma_req === 1'b1) req_cnt++;
            if (rst) begin
                pend_cnt = 0;
                gap      = 0;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.dma_end = 1'b1;
                    if (cur.rnw) bus.dma_rd = mem_rd(cur.addr);
                    else         mem[cur.addr] = cur.wd;
                end
            end else if (bus.dma_req === 1'b1 && !(bus.dma_rnw ? stall_rd : stall_wr)) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    cur.rnw  = bus.dma_rnw;
                    cur.addr = bus.dma_addr;
                    cur.wd   = bus.dma_wd;
                    log_q.push_back(cur);
                    bus.dma_ack = 1'b1;
                    lat = $urandom_range(lat_hi, lat_lo);
                    gap = $urandom_range(gap_hi, 0);
                    if (lat == 0) begin
                        bus.dma_end = 1'b1;
                        if (cur.rnw) bus.dma_rd = mem_rd(cur.addr);
                        else         mem[cur.addr] = cur.wd;
                    end else begin
                        pend_cnt = lat;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    // Reference: byte i reads src+i*sinc (copy) then writes dst+i*dinc, addresses mod 2^AW.
    task automatic build_exp(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len,
                             input logic fill, input logic [7:0] pat, input logic si, input logic di);
        logic [AW-1:0] sa, da;
        logic [7:0]    b;
        acc_t          e;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            sa = AW'(int'(s) + (si ? i : 0));
            da = AW'(int'(d) + (di ? i : 0));
            if (fill) begin
                b = pat;
            end else begin
                b = ref_rd(sa);
                e.rnw = 1'b1; e.addr = sa; e.wd = 8'h00;
                exp_q.push_back(e);
            end
            ref_mem[da] = b;
            e.rnw = 1'b0; e.addr = da; e.wd = b;
            exp_q.push_back(e);
        end
    endtask

    task automatic prep(input int llo, input int lhi, input int ghi);
        mem.delete();
        ref_mem.delete();
        log_q.delete();
        exp_q.delete();
        lat_lo = llo; lat_hi = lhi; gap_hi = ghi;
        stall_rd = 0; stall_wr = 0;
        @(negedge clk); #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len,
                               input logic fill, input logic [7:0] pat, input logic si, input logic di);
        cfg_src = s; cfg_dst = d; cfg_len = LW'(len);
        cfg_fill = fill; cfg_pat = pat; cfg_sinc = si; cfg_dinc = di;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit to);
        int n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        to = (done_cnt == d0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (bus.dma_req !== 1'b0 || bus.dma_rnw !== 1'b1) begin
            bad++; $display("FAIL reset_req_rnw got=%b%b want=01", bus.dma_req, bus.dma_rnw);
        end
        total++;
        if (bus.dma_addr !== '0 || bus.dma_wd !== 8'h00) begin
            bad++; $display("FAIL reset_addr_wd got=%h/%h want=0/0", bus.dma_addr, bus.dma_wd);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
            bad++; $display("FAIL reset_status got=%b%b%b want=000", busy, done, aborted);
        end
        total++;
        if (remaining !== '0) begin
            bad++; $display("FAIL reset_remaining got=%0d want=0", remaining);
        end
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_copy();
        int d0;
        bit to;
        prep(1, 2, 1);
        mem[21'h08001] = 8'hA1; mem[21'h08002] = 8'hA2; mem[21'h08003] = 8'hA3;
        ref_mem[21'h08001] = 8'hA1; ref_mem[21'h08002] = 8'hA2; ref_mem[21'h08003] = 8'hA3;
        build_exp(21'h08001, 21'h09000, 3, 1'b0, 8'h00, 1'b1, 1'b1);
        d0 = done_cnt;
        pulse_start(21'h08001, 21'h09000, 3, 1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL copy_busy got=%b want=1", busy); end
        wait_done(d0, to);
        total++;
        if (to) begin bad++; $display("FAIL copy_timeout got=no_done want=done"); end
        repeat (3) begin @(negedge clk); #1; end
        total++;
        if (log_q.size() != exp_q.size()) begin
            bad++; $display("FAIL copy_count got=%0d want=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            total++;
            if (log_q[i].rnw !== exp_q[i].rnw || log_q[i].addr !== exp_q[i].addr ||
                (!exp_q[i].rnw && log_q[i].wd !== exp_q[i].wd)) begin
                bad++;
                $display("FAIL copy_acc[%0d] got=%b/%h/%h want=%b/%h/%h", i, log_q[i].rnw,
                         log_q[i].addr, log_q[i].wd, exp_q[i].rnw, exp_q[i].addr, exp_q[i].wd);
            end
        end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL copy_done_count got=%0d want=1", done_cnt - d0); end
        total++;
        if (remaining !== '0 || aborted !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL copy_final got=rem%0d/ab%b/busy%b want=rem0/ab0/busy0", remaining, aborted, busy);
        end
    endtask

    task automatic test_fill();
        int d0;
        bit to;
        prep(0, 2, 0);
        build_exp(21'h00123, 21'h0A000, 4, 1'b1, 8'h5C, 1'b1, 1'b0);
        d0 = done_cnt;
        pulse_start(21'h00123, 21'h0A000, 4, 1'b1, 8'h5C, 1'b1, 1'b0);
        wait_done(d0, to);
        total++;
        if (to) begin bad++; $display("FAIL fill_timeout got=no_done want=done"); end
        repeat (3) begin @(negedge clk); #1; end
        total++;
        if (log_q.size() != exp_q.size()) begin
            bad++; $display("FAIL fill_count got=%0d want=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            total++;
            if (log_q[i].rnw !== exp_q[i].rnw || log_q[i].addr !== exp_q[i].addr ||
                (!exp_q[i].rnw && log_q[i].wd !== exp_q[i].wd)) begin
                bad++;
                $display("FAIL fill_acc[%0d] got=%b/%h/%h want=%b/%h/%h", i, log_q[i].rnw,
                         log_q[i].addr, log_q[i].wd, exp_q[i].rnw, exp_q[i].addr, exp_q[i].wd);
            end
        end
        total++;
        if (remaining !== '0 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL fill_final got=rem%0d/dones%0d want=rem0/dones1", remaining, done_cnt - d0);
        end
    endtask

    task automatic test_zero_len();
        int d0, r0;
        prep(1, 1, 0);
        d0 = done_cnt;
        r0 = req_cnt;
        pulse_start(21'h00010, 21'h00020, 0, 1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_done_pulse got=done%b/busy%b want=done1/busy0", done, busy);
        end
        @(negedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_done_end got=done%b/busy%b want=done0/busy0", done, busy);
        end
        repeat (4) begin @(negedge clk); #1; end
        total++;
        if (req_cnt != r0 || log_q.size() != 0 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL zero_no_bus got=reqs%0d/acc%0d/dones%0d want=0/0/1",
                            req_cnt - r0, log_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_abort_wait();
        int d0, n;
        bit to;
        prep(4, 4, 0);
        build_exp(21'h00100, 21'h00200, 5, 1'b0, 8'h00, 1'b1, 1'b1);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        d0 = done_cnt;
        pulse_start(21'h00100, 21'h00200, 5, 1'b0, 8'h00, 1'b1, 1'b1);
        n = 0;
        while (log_q.size() < 3 && n < 100) begin @(negedge clk); #1; n++; end
        @(negedge clk); #1;
        total++;
        if (n >= 100 || bus.dma_req !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_in_rd_wait got=n%0d/req%b/busy%b want=req0/busy1", n, bus.dma_req, busy);
        end
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        wait_done(d0, to);
        total++;
        if (to) begin bad++; $display("FAIL abort_timeout got=no_done want=done"); end
        repeat (6) begin @(negedge clk); #1; end
        total++;
        if (log_q.size() != exp_q.size()) begin
            bad++; $display("FAIL abort_count got=%0d want=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            total++;
            if (log_q[i].rnw !== exp_q[i].rnw || log_q[i].addr !== exp_q[i].addr ||
                (!exp_q[i].rnw && log_q[i].wd !== exp_q[i].wd)) begin
                bad++;
                $display("FAIL abort_acc[%0d] got=%b/%h/%h want=%b/%h/%h", i, log_q[i].rnw,
                         log_q[i].addr, log_q[i].wd, exp_q[i].rnw, exp_q[i].addr, exp_q[i].wd);
            end
        end
        total++;
        if (aborted !== 1'b1 || remaining !== LW'(4) || done_cnt - d0 != 1) begin
            bad++; $display("FAIL abort_final got=ab%b/rem%0d/dones%0d want=ab1/rem4/dones1",
                            aborted, remaining, done_cnt - d0);
        end
    endtask

    task automatic test_abort_req();
        int d0, n, r0;
        bit to;
        prep(1, 1, 0);
        stall_rd = 1;
        d0 = done_cnt;
        pulse_start(21'h00500, 21'h00600, 2, 1'b0, 8'h00, 1'b1, 1'b1);
        n = 0;
        while (bus.dma_req !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk); #1;
        total++;
        if (bus.dma_req !== 1'b1) begin bad++; $display("FAIL req_hold got=%b want=1", bus.dma_req); end
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        total++;
        if (bus.dma_req !== 1'b0) begin bad++; $display("FAIL abort_req_drop got=%b want=0", bus.dma_req); end
        wait_done(d0, to);
        stall_rd = 0;
        r0 = req_cnt;
        repeat (5) begin @(negedge clk); #1; end
        total++;
        if (to || aborted !== 1'b1 || remaining !== LW'(2) || req_cnt != r0 || log_q.size() != 0) begin
            bad++; $display("FAIL abort_req_final got=to%b/ab%b/rem%0d/reqs%0d want=to0/ab1/rem2/reqs0",
                            to, aborted, remaining, req_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        bit to;
        prep(0, 0, 0);
        build_exp(21'h00300, 21'h00400, 3, 1'b0, 8'h00, 1'b1, 1'b1);
        d0 = done_cnt;
        pulse_start(21'h00300, 21'h00400, 3, 1'b0, 8'h00, 1'b1, 1'b1);
        pulse_start(21'h00700, 21'h00800, 7, 1'b1, 8'hEE, 1'b0, 1'b1);
        wait_done(d0, to);
        total++;
        if (to) begin bad++; $display("FAIL b2b_timeout got=no_done want=done"); end
        repeat (12) begin @(negedge clk); #1; end
        total++;
        if (log_q.size() != exp_q.size()) begin
            bad++; $display("FAIL b2b_count got=%0d want=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            total++;
            if (log_q[i].rnw !== exp_q[i].rnw || log_q[i].addr !== exp_q[i].addr ||
                (!exp_q[i].rnw && log_q[i].wd !== exp_q[i].wd)) begin
                bad++;
                $display("FAIL b2b_acc[%0d] got=%b/%h/%h want=%b/%h/%h", i, log_q[i].rnw,
                         log_q[i].addr, log_q[i].wd, exp_q[i].rnw, exp_q[i].addr, exp_q[i].wd);
            end
        end
        total++;
        if (done_cnt - d0 != 1 || busy !== 1'b0 || aborted !== 1'b0) begin
            bad++; $display("FAIL b2b_final got=dones%0d/busy%b/ab%b want=1/0/0", done_cnt - d0, busy, aborted);
        end
    endtask

    task automatic test_reset_mid();
        int n, r0;
        prep(1, 1, 0);
        stall_wr = 1;
        pulse_start(21'h00900, 21'h00A00, 3, 1'b0, 8'h00, 1'b1, 1'b1);
        n = 0;
        while (!(bus.dma_req === 1'b1 && bus.dma_rnw === 1'b0) && n < 50) begin @(negedge clk); #1; n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL rstmid_wr_req got=timeout want=wr_req"); end
        rst = 1'b1;
        @(negedge clk); #1;
        total++;
        if (bus.dma_req !== 1'b0 || busy !== 1'b0 || remaining !== '0) begin
            bad++; $display("FAIL rstmid_state got=req%b/busy%b/rem%0d want=0/0/0", bus.dma_req, busy, remaining);
        end
        rst = 1'b0;
        stall_wr = 0;
        r0 = req_cnt;
        repeat (5) begin @(negedge clk); #1; end
        total++;
        if (req_cnt != r0) begin bad++; $display("FAIL rstmid_idle got=reqs%0d want=0", req_cnt - r0); end
    endtask

    task automatic test_random();
        int d0, len;
        bit to;
        logic [AW-1:0] s, d;
        logic fl, si, di;
        logic [7:0] p;
        for (int it = 0; it < 10; it++) begin
            prep(0, 3, 2);
            s  = ($urandom_range(1, 0) == 1) ? AW'($urandom) : ('1 - AW'($urandom_range(2, 0)));
            d  = ($urandom_range(1, 0) == 1) ? AW'($urandom) : ('1 - AW'($urandom_range(2, 0)));
            len = $urandom_range(6, 1);
            fl = 1'($urandom_range(1, 0));
            si = 1'($urandom_range(1, 0));
            di = 1'($urandom_range(1, 0));
            p  = 8'($urandom);
            build_exp(s, d, len, fl, p, si, di);
            d0 = done_cnt;
            pulse_start(s, d, len, fl, p, si, di);
            wait_done(d0, to);
            total++;
            if (to) begin bad++; $display("FAIL rand%0d_timeout got=no_done want=done", it); end
            repeat (3) begin @(negedge clk); #1; end
            total++;
            if (log_q.size() != exp_q.size()) begin
                bad++; $display("FAIL rand%0d_count got=%0d want=%0d", it, log_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
                total++;
                if (log_q[i].rnw !== exp_q[i].rnw || log_q[i].addr !== exp_q[i].addr ||
                    (!exp_q[i].rnw && log_q[i].wd !== exp_q[i].wd)) begin
                    bad++;
                    $display("FAIL rand%0d_acc[%0d] got=%b/%h/%h want=%b/%h/%h", it, i, log_q[i].rnw,
                             log_q[i].addr, log_q[i].wd, exp_q[i].rnw, exp_q[i].addr, exp_q[i].wd);
                end
            end
            total++;
            if (remaining !== '0 || aborted !== 1'b0 || done_cnt - d0 != 1) begin
                bad++; $display("FAIL rand%0d_final got=rem%0d/ab%b/dones%0d want=0/0/1",
                                it, remaining, aborted, done_cnt - d0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_fill = 1'b0;
        cfg_pat = 8'h00; cfg_sinc = 1'b0; cfg_dinc = 1'b0;
        test_reset();
        test_copy();
        test_fill();
        test_zero_len();
        test_abort_wait();
        test_abort_req();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
